mdu: RTL and testbench

- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Takes the same A/B operands from the register file.
- Produces 64-bit results in the architectural HI/LO registers.
- Raises busy so the control unit can stall the PC while an operation runs; handles MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/mdu.sv | 152 +++++++++++++++
 tb/tb_mdu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative 32-edge multiply/divide unit with HI/LO registers
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   a_orig;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_p;
    logic               neg_r;
    logic               div_zero;
`ifdef MDU_MADD_EN
    logic               is_madd;
`endif

    logic               op_mul;
    logic               op_div;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        op_mul = (op == 3'b000) || (op == 3'b001);
`ifdef MDU_MADD_EN
        op_mul = op_mul || (op[2:1] == 2'b11);
`endif
        op_div    = (op[2:1] == 2'b01);
        signed_op = ~op[0] && (op[2:1] != 2'b10);
        a_neg     = signed_op & A[WIDTH-1];
        b_neg     = signed_op & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
    end

    // Multiply: lower half holds the multiplier, shifted out LSB-first.
    // Divide: upper half is the partial remainder, lower half the dividend/quotient.
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, m};
        div_diff  = div_shift[WIDTH-1:0] - m;
        prod      = neg_p ? -p : p;
        quo       = neg_p ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem       = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            p        <= '0;
            m        <= '0;
            a_orig   <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`ifdef MDU_MADD_EN
            is_madd  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == 3'b100) begin
                            hi <= A;
                        end else if (op == 3'b101) begin
                            lo <= A;
                        end else if (op_mul || op_div) begin
                            busy     <= 1'b1;
                            cnt      <= '0;
                            a_orig   <= A;
                            is_div   <= op_div;
                            neg_p    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= (B == '0);
                            p        <= {{WIDTH{1'b0}}, op_div ? a_mag : b_mag};
                            m        <= op_div ? b_mag : a_mag;
                            state    <= op_div ? DIV : MUL;
`ifdef MDU_MADD_EN
                            is_madd  <= op[2];
`endif
                        end
                    end
                end
                MUL, DIV: begin
                    if (state == MUL) begin
                        p <= {mul_sum, p[WIDTH-1:1]};
                    end else begin
                        p <= {div_ge ? div_diff : div_shift[WIDTH-1:0], p[WIDTH-2:0], div_ge};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (div_zero) begin
                            hi <= a_orig;
                            lo <= '1;
                        end else begin
                            hi <= rem;
                            lo <= quo;
                        end
`ifdef MDU_MADD_EN
                    end else if (is_madd) begin
                        {hi, lo} <= {hi, lo} + prod;
`endif
                    end else begin
                        {hi, lo} <= prod;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for the mdu multiply/divide unit
module tb_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;

    mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = 32'hDEADBEEF; B = 32'h0BADF00D;
    endtask

    // Bounded wait for done; reports edges waited, busy samples and whether hi/lo held.
    task automatic wait_done(output int n, output int nb, output bit held);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo; n = 0; nb = 0; held = 1'b1;
        while (!done && n < 100) begin
            if (busy) nb++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%0b exp=0", done); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
    endtask

    task automatic test_mult;
        int n, nb; bit held;
        issue(3'b000, 32'hFFFFFFFD, 32'h00000005);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mult_busy_e0 got=%0b exp=1", busy); end
        wait_done(n, nb, held);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL mult_latency got=%0d exp=33", n); end
        vectors++; if (nb !== 33) begin miscompares++; $display("FAIL mult_busy_cycles got=%0d exp=33", nb); end
        vectors++; if (!held) begin miscompares++; $display("FAIL mult_hilo_hold got=changed exp=held"); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mult_busy_done got=%0b exp=0", busy); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi got=%h exp=FFFFFFFF", hi); end
        vectors++; if (lo !== 32'hFFFFFFF1) begin miscompares++; $display("FAIL mult_lo got=%h exp=FFFFFFF1", lo); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mult_done_pulse got=%0b exp=0", done); end
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n, nb, held);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL multu_latency got=%0d exp=33", n); end
        vectors++; if (hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi got=%h exp=FFFFFFFE", hi); end
        vectors++; if (lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_div;
        int n, nb; bit held;
        issue(3'b010, 32'hFFFFFFF9, 32'h00000002);
        wait_done(n, nb, held);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL div_latency got=%0d exp=33", n); end
        vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo got=%h exp=FFFFFFFD", lo); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi got=%h exp=FFFFFFFF", hi); end
        issue(3'b011, 32'h00000007, 32'h00000002);
        wait_done(n, nb, held);
        vectors++; if (lo !== 32'h3) begin miscompares++; $display("FAIL divu_lo got=%h exp=00000003", lo); end
        vectors++; if (hi !== 32'h1) begin miscompares++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
    endtask

    task automatic test_div_bounds;
        int n, nb; bit held;
        issue(3'b011, 32'h00000007, 32'h00000000);
        wait_done(n, nb, held);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL divu0_latency got=%0d exp=33", n); end
        vectors++; if (hi !== 32'h7) begin miscompares++; $display("FAIL divu0_hi got=%h exp=00000007", hi); end
        vectors++; if (lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL divu0_lo got=%h exp=FFFFFFFF", lo); end
        issue(3'b010, 32'hFFFFFFF9, 32'h00000000);
        wait_done(n, nb, held);
        vectors++; if (hi !== 32'hFFFFFFF9) begin miscompares++; $display("FAIL div0_hi got=%h exp=FFFFFFF9", hi); end
        vectors++; if (lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div0_lo got=%h exp=FFFFFFFF", lo); end
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, nb, held);
        vectors++; if (lo !== 32'h80000000) begin miscompares++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_mthi_mtlo;
        issue(3'b100, 32'h12345678, 32'h0);
        vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
        issue(3'b101, 32'h9ABCDEF0, 32'h0);
        vectors++; if (lo !== 32'h9ABCDEF0) begin miscompares++; $display("FAIL mtlo_lo got=%h exp=9ABCDEF0", lo); end
        vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mtlo_busy_done got=%0b%0b exp=00", busy, done); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mtlo_no_done got=%0b exp=0", done); end
    endtask

    task automatic test_ignore_start;
        int ndone = 0;
        logic [31:0] h = '0, l = '0;
        issue(3'b001, 32'd2, 32'd3);
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin start = 1'b1; op = 3'b011; A = 32'd100; B = 32'd7; end
            if (c == 11) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin ndone++; h = hi; l = lo; end
        end
        vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        vectors++; if (h !== 32'h0) begin miscompares++; $display("FAIL ignore_hi got=%h exp=00000000", h); end
        vectors++; if (l !== 32'h6) begin miscompares++; $display("FAIL ignore_lo got=%h exp=00000006", l); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_busy_after got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_abort;
        int n, nb; bit held;
        issue(3'b001, 32'd5, 32'd5);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got=%0b exp=0", done); end
        vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL abort_hilo got=%h_%h exp=00000000_00000000", hi, lo); end
        issue(3'b001, 32'd4, 32'd4);
        wait_done(n, nb, held);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL after_abort_latency got=%0d exp=33", n); end
        vectors++; if (lo !== 32'd16 || hi !== 32'h0) begin miscompares++; $display("FAIL after_abort_result got=%h_%h exp=00000000_00000010", hi, lo); end
    endtask

    task automatic test_back_to_back;
        int n, nb; bit held;
        issue(3'b001, 32'd3, 32'd7);
        wait_done(n, nb, held);
        vectors++; if (lo !== 32'd21) begin miscompares++; $display("FAIL b2b_first_lo got=%h exp=00000015", lo); end
        issue(3'b011, 32'd100, 32'd7);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got=%0b exp=1", busy); end
        wait_done(n, nb, held);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=33", n); end
        vectors++; if (lo !== 32'd14 || hi !== 32'd2) begin miscompares++; $display("FAIL b2b_result got=%h_%h exp=00000002_0000000e", hi, lo); end
    endtask

    task automatic test_madd;
        int n, nb; bit held;
        issue(3'b100, 32'h0, 32'h0);
        issue(3'b101, 32'h1, 32'h0);
`ifdef MDU_MADD_EN
        issue(3'b110, 32'd2, 32'd3);
        wait_done(n, nb, held);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL madd_latency got=%0d exp=33", n); end
        vectors++; if (lo !== 32'd7 || hi !== 32'h0) begin miscompares++; $display("FAIL madd_result got=%h_%h exp=00000000_00000007", hi, lo); end
        issue(3'b101, 32'h0, 32'h0);
        issue(3'b110, 32'hFFFFFFFF, 32'h1);
        wait_done(n, nb, held);
        vectors++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL madd_neg got=%h_%h exp=FFFFFFFF_FFFFFFFF", hi, lo); end
`else
        issue(3'b110, 32'd2, 32'd3);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL madd_off_busy got=%0b exp=0", busy); end
        wait_done(n, nb, held);
        vectors++; if (n !== 100) begin miscompares++; $display("FAIL madd_off_done got=done_after_%0d exp=no_done", n); end
        vectors++; if (lo !== 32'h1 || hi !== 32'h0) begin miscompares++; $display("FAIL madd_off_hilo got=%h_%h exp=00000000_00000001", hi, lo); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_bounds();
        test_mthi_mtlo();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_madd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
